// File: rtl/alu_issue_seq.sv
// alu_issue_seq: single-issue RV32I ALU decode and sequencer stage.
// Owns a 32x32 register file; runs IDLE -> EXEC -> WB per instruction.
module alu_issue_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        alu_en,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [1:0]  state_q, state_d;
  logic        alu_en_q, alu_en_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        done_q, done_d;
  logic        ill_q, ill_d;

  logic [31:0] regs_q [32];

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_s;
  logic [31:0] shamt_i;
  logic [31:0] shamt_r;
  logic        is_r;
  logic        is_i;
  logic        accept;

  logic        dec_legal;
  logic [3:0]  dec_op;
  logic [31:0] dec_opb;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign is_r = (opcode == OPC_R);
  assign is_i = (opcode == OPC_I);

  // x0 is hardwired to zero on every read port
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

  assign imm_s   = {{20{instr[31]}}, instr[31:20]};
  assign shamt_i = {27'd0, instr[24:20]};
  assign shamt_r = {27'd0, rs2_val[4:0]};

  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;

  assign alu_en  = alu_en_q;
  assign alu_opA = opa_q;
  assign alu_opB = opb_q;
  assign alu_op  = op_q;
  assign done    = done_q;
  assign illegal = ill_q;

  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

  // Decode opcode/funct fields into ALU opcode and operand B
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_opb   = rs2_val;
    unique case (1'b1)
      is_r: begin
        dec_opb = rs2_val;
        case (f3)
          3'b000: begin
            if (f7 == F7_ZERO) begin
              dec_legal = 1'b1;
              dec_op    = OP_ADD;
            end else if (f7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_op    = OP_SUB;
            end
          end
          3'b111: begin
            dec_legal = 1'b1;
            dec_op    = OP_AND;
          end
          3'b110: begin
            dec_legal = 1'b1;
            dec_op    = OP_OR;
          end
          3'b100: begin
            dec_legal = 1'b1;
            dec_op    = OP_XOR;
          end
          3'b001: begin
            dec_legal = (f7 == F7_ZERO);
            dec_op    = OP_SLL;
            dec_opb   = shamt_r;
          end
          3'b101: begin
            dec_legal = (f7 == F7_ZERO);
            dec_op    = OP_SRL;
            dec_opb   = shamt_r;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      is_i: begin
        dec_opb = imm_s;
        case (f3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_op    = OP_ADD;
          end
          3'b111: begin
            dec_legal = 1'b1;
            dec_op    = OP_AND;
          end
          3'b110: begin
            dec_legal = 1'b1;
            dec_op    = OP_OR;
          end
          3'b100: begin
            dec_legal = 1'b1;
            dec_op    = OP_XOR;
          end
          3'b001: begin
            dec_legal = (f7 == F7_ZERO);
            dec_op    = OP_SLL;
            dec_opb   = shamt_i;
          end
          3'b101: begin
            dec_legal = (f7 == F7_ZERO);
            dec_op    = OP_SRL;
            dec_opb   = shamt_i;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state for sequencer; operands hold outside of a legal accept
  always_comb begin
    state_d  = state_q;
    alu_en_d = 1'b0;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            state_d  = S_EXEC;
            alu_en_d = 1'b1;
            opa_d    = rs1_val;
            opb_d    = dec_opb;
            op_d     = dec_op;
            rd_d     = rd;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        done_d  = 1'b1;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      alu_en_q <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      op_q     <= 4'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      alu_en_q <= alu_en_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
    end
  end

  // Register file: cleared on reset, written at the edge ending WB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if ((state_q == S_WB) && (rd_q != 5'd0)) begin
      regs_q[rd_q] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed bench for alu_issue_seq.
// Includes a negedge ALU model that responds to alu_en.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        alu_en;
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        done;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  logic        o_en;
  logic [31:0] o_opa;
  logic [31:0] o_opb;
  logic [3:0]  o_op;
  logic        o_ill;
  logic        o_ill2;
  logic        o_rdy0;
  logic        o_rdy2;
  logic        o_done;
  int          o_en_cnt;
  int          o_done_cnt;
  logic [31:0] rv;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_en      (alu_en),
    .alu_opA     (alu_opA),
    .alu_opB     (alu_opB),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .done        (done),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always @(negedge clk) begin
    if (alu_en) begin
      case (alu_op)
        4'd0: alu_result <= alu_opA + alu_opB;
        4'd1: alu_result <= alu_opA - alu_opB;
        4'd2: alu_result <= alu_opA & alu_opB;
        4'd3: alu_result <= alu_opA | alu_opB;
        4'd4: alu_result <= alu_opA ^ alu_opB;
        4'd5: alu_result <= alu_opA << alu_opB[4:0];
        4'd6: alu_result <= alu_opA >> alu_opB[4:0];
        default: alu_result <= 32'd0;
      endcase
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Drive one instruction from a negedge and record three cycles of outputs
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%0b want=1", instr_ready);
    end
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 32'd0;
    o_en = alu_en;
    o_opa = alu_opA;
    o_opb = alu_opB;
    o_op = alu_op;
    o_ill = illegal;
    o_rdy0 = instr_ready;
    o_en_cnt = int'(alu_en);
    o_done_cnt = int'(done);
    @(negedge clk);
    o_done = done;
    o_ill2 = illegal;
    o_en_cnt += int'(alu_en);
    o_done_cnt += int'(done);
    @(negedge clk);
    o_rdy2 = instr_ready;
    o_en_cnt += int'(alu_en);
    o_done_cnt += int'(done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'd0;
    dbg_addr = 5'd0;
    alu_result = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b want=0", instr_ready); end
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL rst_alu_en got=%0b want=0", alu_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b want=0", done); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%0b want=0", illegal); end
    checks++; if ({alu_opA, alu_opB, alu_op} !== 68'd0) begin errors++; $display("FAIL rst_operands got=%h/%h/%h want=0", alu_opA, alu_opB, alu_op); end
    rst_n = 1'b1;
    rd_reg(5'd1, rv);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_ready got=%0b want=1", instr_ready); end
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL rst_x1 got=%h want=0", rv); end
  endtask

  task automatic test_addi();
    send(32'h00500093);
    checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL addi_en got=%0b want=1", o_en); end
    checks++; if (o_en_cnt != 1) begin errors++; $display("FAIL addi_en_cnt got=%0d want=1", o_en_cnt); end
    checks++; if ({o_opa, o_opb, o_op} !== {32'd0, 32'd5, 4'd0}) begin errors++; $display("FAIL addi_ops got=%h/%h/%h want=0/5/0", o_opa, o_opb, o_op); end
    checks++; if (o_done !== 1'b1 || o_done_cnt != 1) begin errors++; $display("FAIL addi_done got=%0b/%0d want=1/1", o_done, o_done_cnt); end
    checks++; if (o_rdy0 !== 1'b0 || o_rdy2 !== 1'b1) begin errors++; $display("FAIL addi_ready got=%0b/%0b want=0/1", o_rdy0, o_rdy2); end
    rd_reg(5'd1, rv);
    checks++; if (rv !== 32'd5) begin errors++; $display("FAIL addi_x1 got=%h want=5", rv); end
  endtask

  task automatic test_back_to_back();
    send(32'h00700113);
    rd_reg(5'd2, rv);
    checks++; if (rv !== 32'd7) begin errors++; $display("FAIL b2b_x2 got=%h want=7", rv); end
    send(32'h402081B3);
    checks++; if ({o_opa, o_opb, o_op} !== {32'd5, 32'd7, 4'd1}) begin errors++; $display("FAIL sub_ops got=%h/%h/%h want=5/7/1", o_opa, o_opb, o_op); end
    rd_reg(5'd3, rv);
    checks++; if (rv !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_x3 got=%h want=fffffffe", rv); end
  endtask

  task automatic test_imm();
    send(enc_i(12'hFFF, 5'd0, 3'b000, 5'd11));
    checks++; if (o_opb !== 32'hFFFFFFFF) begin errors++; $display("FAIL imm_sext got=%h want=ffffffff", o_opb); end
    send(enc_i(12'h0F0, 5'd11, 3'b100, 5'd12));
    checks++; if ({o_opb, o_op} !== {32'h000000F0, 4'd4}) begin errors++; $display("FAIL xori_ops got=%h/%h want=f0/4", o_opb, o_op); end
    rd_reg(5'd12, rv);
    checks++; if (rv !== 32'hFFFFFF0F) begin errors++; $display("FAIL xori_x12 got=%h want=ffffff0f", rv); end
  endtask

  task automatic test_shift();
    send(enc_i(12'd1, 5'd0, 3'b000, 5'd7));
    send(enc_i(12'd31, 5'd7, 3'b001, 5'd9));
    checks++; if ({o_opb, o_op} !== {32'd31, 4'd5}) begin errors++; $display("FAIL slli_ops got=%h/%h want=1f/5", o_opb, o_op); end
    send(enc_i(12'd1, 5'd9, 3'b000, 5'd1));
    send(enc_i(12'd33, 5'd0, 3'b000, 5'd2));
    rd_reg(5'd1, rv);
    checks++; if (rv !== 32'h80000001) begin errors++; $display("FAIL shift_x1 got=%h want=80000001", rv); end
    send(enc_r(7'd0, 5'd2, 5'd1, 3'b001, 5'd4));
    checks++; if ({o_opa, o_opb, o_op} !== {32'h80000001, 32'd1, 4'd5}) begin errors++; $display("FAIL sll_ops got=%h/%h/%h want=80000001/1/5", o_opa, o_opb, o_op); end
    rd_reg(5'd4, rv);
    checks++; if (rv !== 32'd2) begin errors++; $display("FAIL sll_x4 got=%h want=2", rv); end
    send(enc_i(12'd31, 5'd1, 3'b101, 5'd5));
    checks++; if ({o_opb, o_op} !== {32'd31, 4'd6}) begin errors++; $display("FAIL srli_ops got=%h/%h want=1f/6", o_opb, o_op); end
    rd_reg(5'd5, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL srli_x5 got=%h want=1", rv); end
  endtask

  task automatic test_x0();
    send(32'h00100013);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL x0_done got=%0b want=1", o_done); end
    rd_reg(5'd0, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL x0_read got=%h want=0", rv); end
    send(enc_i(12'd3, 5'd0, 3'b000, 5'd10));
    checks++; if (o_opa !== 32'd0) begin errors++; $display("FAIL x0_rs1 got=%h want=0", o_opa); end
  endtask

  task automatic test_illegal();
    send(32'h00000073);
    checks++; if (o_ill !== 1'b1 || o_ill2 !== 1'b0) begin errors++; $display("FAIL ecall_pulse got=%0b/%0b want=1/0", o_ill, o_ill2); end
    checks++; if (o_en_cnt != 0 || o_done_cnt != 0) begin errors++; $display("FAIL ecall_quiet got=%0d/%0d want=0/0", o_en_cnt, o_done_cnt); end
    checks++; if (o_rdy0 !== 1'b1) begin errors++; $display("FAIL ecall_ready got=%0b want=1", o_rdy0); end
    rd_reg(5'd3, rv);
    checks++; if (rv !== 32'hFFFFFFFE) begin errors++; $display("FAIL ecall_x3 got=%h want=fffffffe", rv); end
    send(enc_r(7'b0100001, 5'd2, 5'd1, 3'b000, 5'd3));
    checks++; if (o_ill !== 1'b1 || o_en_cnt != 0) begin errors++; $display("FAIL badsub got=%0b/%0d want=1/0", o_ill, o_en_cnt); end
    send(enc_i(12'h41F, 5'd1, 3'b101, 5'd5));
    checks++; if (o_ill !== 1'b1 || o_en_cnt != 0) begin errors++; $display("FAIL badsrli got=%0b/%0d want=1/0", o_ill, o_en_cnt); end
    rd_reg(5'd5, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL badsrli_x5 got=%h want=1", rv); end
  endtask

  task automatic test_exec_reset();
    int dn;
    instr = enc_i(12'd9, 5'd0, 3'b000, 5'd6);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if (alu_en !== 1'b1 || alu_opB !== 32'd9) begin errors++; $display("FAIL xr_exec got=%0b/%h want=1/9", alu_en, alu_opB); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({alu_en, done, illegal} !== 3'b000) begin errors++; $display("FAIL xr_flags got=%b want=000", {alu_en, done, illegal}); end
    checks++; if ({alu_opA, alu_opB, alu_op} !== 68'd0) begin errors++; $display("FAIL xr_ops got=%h/%h/%h want=0", alu_opA, alu_opB, alu_op); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL xr_ready_low got=%0b want=0", instr_ready); end
    rst_n = 1'b1;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      dn += int'(done);
    end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL xr_ready got=%0b want=1", instr_ready); end
    checks++; if (dn != 0) begin errors++; $display("FAIL xr_done got=%0d want=0", dn); end
    rd_reg(5'd6, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL xr_x6 got=%h want=0", rv); end
    rd_reg(5'd1, rv);
    checks++; if (rv !== 32'd0) begin errors++; $display("FAIL xr_x1 got=%h want=0", rv); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_imm();
    test_shift();
    test_x0();
    test_illegal();
    test_exec_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Single-issue decode/sequencer stage that sits directly upstream of the ALU. It accepts one RV32I ALU-class instruction per handshake and decodes it. It reads operands from an internal 32×32 register file, drives the ALU operand/opcode/enable inputs for exactly one cycle, and then writes the ALU result back to `rd`. It implements the ALU opcode map 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl.

## Interface
- Parameters: none. XLEN is 32 and the register count is 32, both fixed.
- `clk`  in  1  the single clock; all state updates on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `instr_valid`  in  1  the upstream instruction is valid.
- `instr_ready`  out  1  the stage can accept an instruction; equals 1 only in IDLE with `rst_n`=1.
- `instr`  in  32  RV32I instruction word.
- `alu_en`  out  1  ALU enable; high for exactly one cycle (EXEC) per legal instruction.
- `alu_opA`  out  32  ALU operand A.
- `alu_opB`  out  32  ALU operand B.
- `alu_op`  out  4  ALU opcode (0–6).
- `alu_result`  in  32  ALU output; the ALU updates it on the negedge inside EXEC.
- `done`  out  1  one-cycle pulse during WB.
- `illegal`  out  1  one-cycle pulse; the accepted instruction was not a supported ALU op.
- `dbg_addr`  in  5  debug register-file read address.
- `dbg_data`  out  32  combinational read of `regs[dbg_addr]`; reads 0 for x0.

## Operation
- **States:** IDLE → EXEC → WB → IDLE.
- **Accept:** a transfer occurs on a posedge where `instr_valid`=1 and `instr_ready`=1 (IDLE only).
- **Decode at accept:**
  - R-type, opcode 0110011:
    - f3=000: f7=0000000 is add (0); f7=0100000 is sub (1).
    - f3=111 is and (2); f3=110 is or (3); f3=100 is xor (4).
    - f3=001 with f7=0 is sll (5); f3=101 with f7=0 is srl (6).
  - I-type, opcode 0010011:
    - f3 = 000 addi, 111 andi, 110 ori, 100 xori.
    - f3 = 001 slli and 101 srli, both requiring imm[11:5]=0.
  - Any other encoding is illegal.
- **Operands at accept:**
  - opA = `regs[rs1]`.
  - R-type opB = `regs[rs2]`; for sll/srl, opB = `regs[rs2]` & 0x1F.
  - I-type opB = sign-extended `instr[31:20]`; for slli/srli, opB = zero-extended `instr[24:20]`.
  - The register-file read at accept observes every write completed on earlier edges.
- **Legal accept:** latch `alu_opA`, `alu_opB`, `alu_op` and `rd`; go to EXEC.
- **Illegal accept:** stay in IDLE and pulse `illegal` next cycle. No `alu_en`, no write, no `done`.
- **EXEC (1 cycle):** `alu_en`=1 with operands and opcode stable. Go to WB.
- **WB (1 cycle):**
  - `alu_en`=0 and `done`=1.
  - At the posedge ending WB, write `regs[rd]` ← `alu_result`, suppressed when rd=0. x0 always reads 0.
  - Go to IDLE.
- **Output holding:** `alu_opA`, `alu_opB` and `alu_op` hold their last values outside EXEC.
- **Arithmetic:** all arithmetic is performed by the ALU. This stage does only sign/zero extension and shift-amount masking.
- **Reset:** `rst_n`=0 at any posedge, in any state, does the following:
  - State → IDLE.
  - All 32 registers ← 0.
  - `alu_en`, `alu_opA`, `alu_opB`, `alu_op`, `done`, `illegal` ← 0.
  - Any in-flight instruction is dropped with no write-back.
  - `instr_ready`=0 while `rst_n`=0.

## Timing
- Accept edge is T0. EXEC runs T0→T1 with `alu_en`=1, and the ALU latches its result at the negedge within that cycle. WB runs T1→T2 with `done`=1, and the register write happens at T2.
- The next accept is possible at T3, when `instr_ready`=1 again during T2→T3. Throughput is one instruction per 3 cycles.
- Back-to-back dependent instructions need no forwarding, because the write at T2 precedes the read at T3.
- `alu_result` must remain stable from the EXEC negedge until T2; the ALU holds it because `alu_en`=0 in WB.
- After an illegal accept, `illegal`=1 for one cycle (T0→T1) and `instr_ready` stays 1, so a new accept is possible at T1.
- `instr_valid` held high while not ready has no effect; the instruction is not consumed.

## Test plan
- After reset, send `0x00500093` (addi x1,x0,5). Expected: `alu_en`=1 for exactly 1 cycle with opA=0, opB=5, op=0; `done` at T1; `dbg_data`(x1)=5 after T2.
- Send x1=5 and `0x00700113` (x2=7), then `0x402081B3` (sub x3,x1,x2). Expected: op=1, and x3=0xFFFFFFFE.
- Set x1=0x80000001 and x2=33, then send sll x4,x1,x2. Expected: opB=1, x4=0x00000002. Then send srli x5,x1,31. Expected: opB=31, x5=1.
- Send `0x00100013` (addi x0,x0,1). Expected: `done` pulses, and x0 still reads 0.
- Send `0x00000073` (ecall). Expected: `illegal` pulse, `alu_en` stays 0, no register changes, `instr_ready`=1 on the next cycle. Then sub with f7=0100001. Expected: also illegal.
- Drive `rst_n`=0 during EXEC of addi x6,x0,9. Expected: x6=0, all outputs 0, state IDLE, and `instr_ready`=1 the cycle after `rst_n` returns to 1.
